// File: rtl/nibble_demux_if.sv
// Stream/sample bundle between the nibble stream source and the demux.
interface nibble_demux_if #(
  parameter int ERR_W = 8
);
  logic [4:0]       in_data;
  logic [15:0]      out_data [2];
  logic             out_valid;
  logic             locked;
  logic             sync_err;
  logic [ERR_W-1:0] err_count;

  modport master (output in_data, input out_data, out_valid, locked, sync_err, err_count);
  modport slave  (input in_data, output out_data, out_valid, locked, sync_err, err_count);
endinterface

// File: rtl/nibble_demux.sv
// Rebuilds two 16-bit samples from the 8-word tagged nibble stream.
// Optional: DEMUX_ZERO_ON_LOSS_EN clears out_data when lock is lost.
module nibble_demux #(
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  nibble_demux_if.slave bus
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t                 state_q, state_d;
  logic [2:0]             slot_q, slot_d;
  logic [3:0]             good_q, good_d;
  logic                   prev_tag_q, prev_tag_d;
  logic [1:0][15:0]       sh_q, sh_d;
  logic [1:0][15:0]       dout_q, dout_d;
  logic                   vld_q, vld_d;
  logic                   serr_q, serr_d;
  logic [ERR_W-1:0]       err_q, err_d;

  logic [3:0] nib;
  logic       tag;
  assign nib = bus.in_data[4:1];
  assign tag = bus.in_data[0];

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    good_d     = good_q;
    prev_tag_d = tag;
    sh_d       = sh_q;
    dout_d     = dout_q;
    vld_d      = 1'b0;
    serr_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      HUNT: begin
        if (prev_tag_q && !tag) begin
          sh_d[0] = {12'h000, nib};
          slot_d  = 3'd1;
          good_d  = 4'd0;
          state_d = VERIFY;
        end
      end
      default: begin
        // slot[2] is the channel of the word expected in this slot
        if (tag != slot_q[2]) begin
          serr_d  = 1'b1;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          slot_d  = 3'd0;
          state_d = HUNT;
`ifdef DEMUX_ZERO_ON_LOSS_EN
          if (state_q == LOCKED) dout_d = '0;
`endif
        end else begin
          sh_d[slot_q[2]] = {sh_q[slot_q[2]][11:0], nib};
          slot_d          = slot_q + 3'd1;
          if (slot_q == 3'd7) begin
            if (state_q == LOCKED) begin
              vld_d = 1'b1;
            end else begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_d = LOCKED;
                vld_d   = 1'b1;
              end
            end
            if (vld_d) begin
              dout_d[0] = sh_q[0];
              dout_d[1] = {sh_q[1][11:0], nib};
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      good_q     <= '0;
      prev_tag_q <= 1'b0;
      sh_q       <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      serr_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      good_q     <= good_d;
      prev_tag_q <= prev_tag_d;
      sh_q       <= sh_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      serr_q     <= serr_d;
      err_q      <= err_d;
    end
  end

  assign bus.out_data[0] = dout_q[0];
  assign bus.out_data[1] = dout_q[1];
  assign bus.out_valid   = vld_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.sync_err    = serr_q;
  assign bus.err_count   = err_q;
endmodule

// File: tb/tb_nibble_demux.sv
// Bench for nibble_demux: frame-level reference model plus directed sequences.
module tb_nibble_demux;
  localparam int LOCK = 2;

  logic clk, rst;
  nibble_demux_if #(.ERR_W(8)) bus1();
  nibble_demux_if #(.ERR_W(2)) bus2();

  nibble_demux #(.LOCK_FRAMES(LOCK), .ERR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  nibble_demux #(.LOCK_FRAMES(LOCK), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects the nibbles of a frame by position and
  // assembles samples arithmetically once the whole frame has arrived.
  bit          m_hunt, m_locked, m_prev, m_valid, m_serr;
  int          m_pos, m_ok, m_err1, m_err2;
  logic [3:0]  m_nib [8];
  logic [15:0] m_out [2];

  task automatic model_reset();
    m_hunt = 1; m_locked = 0; m_prev = 0; m_valid = 0; m_serr = 0;
    m_pos = 0; m_ok = 0; m_err1 = 0; m_err2 = 0;
    m_out[0] = 0; m_out[1] = 0;
    for (int i = 0; i < 8; i++) m_nib[i] = 0;
  endtask

  task automatic model_step(input logic [4:0] w);
    bit t, pub;
    t = w[0]; m_valid = 0; m_serr = 0;
    if (m_hunt) begin
      if (m_prev && !t) begin
        m_hunt = 0; m_pos = 1; m_nib[0] = w[4:1]; m_ok = 0;
      end
    end else if (t != (m_pos >= 4)) begin
      m_serr = 1;
      m_err1 = (m_err1 < 255) ? m_err1 + 1 : 255;
      m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
`ifdef DEMUX_ZERO_ON_LOSS_EN
      if (m_locked) begin m_out[0] = 0; m_out[1] = 0; end
`endif
      m_hunt = 1; m_locked = 0;
    end else begin
      m_nib[m_pos] = w[4:1];
      if (m_pos == 7) begin
        pub = m_locked;
        if (!m_locked) begin
          m_ok++;
          if (m_ok == LOCK) begin m_locked = 1; pub = 1; end
        end
        if (pub) begin
          m_out[0] = {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
          m_out[1] = {m_nib[4], m_nib[5], m_nib[6], m_nib[7]};
          m_valid  = 1;
        end
      end
      m_pos = (m_pos + 1) % 8;
    end
    m_prev = t;
  endtask

  task automatic step(input logic [4:0] w);
    bus1.in_data = w;
    bus2.in_data = w;
    model_step(w);
    @(posedge clk);
    #1;
    chk("locked",    bus1.locked,      m_locked);
    chk("out_valid", bus1.out_valid,   m_valid);
    chk("sync_err",  bus1.sync_err,    m_serr);
    chk("err_count", bus1.err_count,   m_err1);
    chk("out_ch0",   bus1.out_data[0], m_out[0]);
    chk("out_ch1",   bus1.out_data[1], m_out[1]);
    chk("err2",      bus2.err_count,   m_err2);
    chk("serr2",     bus2.sync_err,    m_serr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] fw(input logic [15:0] a, input logic [15:0] b, input int s);
    logic [15:0] v;
    int k;
    v = (s >= 4) ? b : a;
    k = 3 - (s % 4);
    return {v[k*4 +: 4], (s >= 4) ? 1'b1 : 1'b0};
  endfunction

  typedef struct {
    logic [4:0] w;
    bit         v;
    bit         l;
  } vec_t;
  vec_t tbl [19];

  logic [15:0] exp_loss;
  logic [15:0] ra, rb;
  logic [4:0]  w;
  int          pulses, rs;
  bit          got;

  initial begin
    // slot-5 start: the 3-word tail is ignored, then frames A and B
    for (int i = 0; i < 19; i++) begin
      tbl[i].w = fw(16'h5A3C, 16'hBEEF, (i + 5) % 8);
      tbl[i].v = (i == 18);
      tbl[i].l = (i == 18);
    end

    rst = 1'b1;
    bus1.in_data = 5'h00;
    bus2.in_data = 5'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch0",    bus1.out_data[0], 0);
    chk("rst_ch1",    bus1.out_data[1], 0);
    chk("rst_valid",  bus1.out_valid,   0);
    chk("rst_locked", bus1.locked,      0);
    chk("rst_serr",   bus1.sync_err,    0);
    chk("rst_err",    bus1.err_count,   0);
    rst = 1'b0;

    got = 0;
    for (int i = 0; i < 20; i++) begin
      step(5'h00);
      if (bus1.out_valid) got = 1;
    end
    chk("idle_valid",  got, 0);
    chk("idle_locked", bus1.locked, 0);
    chk("idle_err",    bus1.err_count, 0);

    // Aligned stream: frame 0 is unseen (no preceding tag 1), lock after 2 more
    for (int i = 0; i < 40; i++) begin
      step(fw(16'hA5C3, 16'h1234, i % 8));
      chk("align_valid", bus1.out_valid, (i >= 23 && i % 8 == 7));
      if (i == 23) begin
        chk("align_ch0", bus1.out_data[0], 16'hA5C3);
        chk("align_ch1", bus1.out_data[1], 16'h1234);
      end
    end
    chk("align_locked", bus1.locked, 1);

    // Tag flip on slot 2 while locked
    for (int s = 0; s < 8; s++) begin
      w = fw(16'hA5C3, 16'h1234, s);
      if (s == 2) w[0] = 1'b1;
      step(w);
      if (s == 2) begin
        chk("flip_serr",   bus1.sync_err, 1);
        chk("flip_err",    bus1.err_count, 1);
        chk("flip_locked", bus1.locked, 0);
      end
    end
`ifdef DEMUX_ZERO_ON_LOSS_EN
    exp_loss = 16'h0000;
`else
    exp_loss = 16'hA5C3;
`endif
    got = 0;
    for (int c = 0; c < 48 && !got; c++) begin
      step(fw(16'hA5C3, 16'h1234, c % 8));
      if (bus1.out_valid) got = 1;
      else chk("loss_ch0", bus1.out_data[0], exp_loss);
    end
    chk("relock", got, 1);

    // Reset at slot 3 of a locked frame
    for (int s = 0; s < 3; s++) step(fw(16'hA5C3, 16'h1234, s));
    bus1.in_data = fw(16'hA5C3, 16'h1234, 3);
    bus2.in_data = bus1.in_data;
    rst = 1'b1;
    #1;
    chk("mrst_ch0",    bus1.out_data[0], 0);
    chk("mrst_ch1",    bus1.out_data[1], 0);
    chk("mrst_locked", bus1.locked, 0);
    chk("mrst_err",    bus1.err_count, 0);
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) step(fw(16'h0F0F, 16'h7E81, i % 8));
    chk("post_ch0", bus1.out_data[0], 16'h0F0F);
    chk("post_ch1", bus1.out_data[1], 16'h7E81);

    // Table: stream starting at slot 5
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].w);
      chk("tbl_valid",  bus1.out_valid, tbl[i].v);
      chk("tbl_locked", bus1.locked,    tbl[i].l);
    end
    chk("tbl_ch0", bus1.out_data[0], 16'h5A3C);
    chk("tbl_ch1", bus1.out_data[1], 16'hBEEF);

    // Five separate mismatches into a 2-bit counter
    do_reset();
    pulses = 0;
    step(5'h03);
    for (int i = 0; i < 5; i++) begin
      step(5'h14);
      step(5'h03);
      if (bus2.sync_err) pulses++;
    end
    chk("sat_pulses", pulses, 5);
    chk("sat_err2",   bus2.err_count, 3);
    chk("sat_err8",   bus1.err_count, 5);

    // Random frames with tag flips, slips and occasional resets
    do_reset();
    rs = 0; ra = 16'($urandom); rb = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 149) == 0) begin
        w = 5'($urandom);
      end else begin
        w = fw(ra, rb, rs);
        if ($urandom_range(0, 39) == 0) w[0] = ~w[0];
        rs++;
        if (rs == 8) begin rs = 0; ra = 16'($urandom); rb = 16'($urandom); end
      end
      step(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
